intdiv_iter_fsm: RTL and testbench

- Sequential radix-2 restoring integer divide/remainder engine for RV DIV/DIVU/REM/REMU.
- Producer side of the integer-divide special-case stage: supplies the held operands, divide-by-zero flag, numerator-small flag and raw pre-result that the special-case stage consumes.
- Sits between the execute-stage issue logic and that special-case stage.
- The special-case stage makes the final selection. This block never substitutes results for the special cases; it only flags them and skips iteration.

---
 rtl/intdiv_iter_fsm.sv | 155 +++++++++++++++
 tb/tb_intdiv_iter_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_iter_fsm.sv
// Radix-2 restoring divide/remainder engine for DIV/DIVU/REM/REMU.
// Optional early termination on dividend leading zeros: INTDIV_EARLYTERM_EN.
module intdiv_iter_fsm #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            signed_op,
  input  logic            rem_op,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] a_q,
  output logic [XLEN-1:0] b_q,
  output logic            rem_op_q,
  output logic            b_zero,
  output logic            a_lt_b,
  output logic [XLEN-1:0] pre_result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, POST, DONE
  } state_t;

  state_t state, state_n;

  logic            signed_q;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] bmag;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] amag_c;
  logic [XLEN-1:0] bmag_c;
  logic            bz_c;
  logic            lt_c;
  logic [XLEN-1:0] dvd_init;
  logic [CW-1:0]   cnt_init;

  assign amag_c = (signed_q && a_q[XLEN-1]) ? -a_q : a_q;
  assign bmag_c = (signed_q && b_q[XLEN-1]) ? -b_q : b_q;
  assign bz_c   = (b_q == '0);
  assign lt_c   = !bz_c && (amag_c < bmag_c);

`ifdef INTDIV_EARLYTERM_EN
  logic [CW-1:0] lz;
  logic          found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found) begin
        if (amag_c[i]) found = 1'b1;
        else lz = lz + 1'b1;
      end
    end
  end

  // Leading zeros only produce zero quotient bits, so skip them.
  assign dvd_init = amag_c << lz;
  assign cnt_init = (lz == CW'(XLEN)) ? CW'(1)
                                      : CW'(XLEN) - lz;
`else
  assign dvd_init = amag_c;
  assign cnt_init = CW'(XLEN);
`endif

  logic [XLEN:0]   sh;
  logic [XLEN:0]   trial;
  logic            ge;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] q_c;
  logic [XLEN-1:0] r_c;

  assign sh    = {rem, dvd[XLEN-1]};
  assign trial = sh - {1'b0, bmag};
  assign ge    = !trial[XLEN];
  assign neg_q = signed_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_r = signed_q && a_q[XLEN-1];
  assign q_c   = neg_q ? -dvd : dvd;
  assign r_c   = neg_r ? -rem : rem;

  assign busy = (state == PREP) || (state == ITER)
             || (state == POST);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = PREP;
      PREP: state_n = (bz_c || lt_c) ? DONE : ITER;
      ITER: if (cnt == CW'(1)) state_n = POST;
      POST: state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      rem_op_q   <= 1'b0;
      signed_q   <= 1'b0;
      b_zero     <= 1'b0;
      a_lt_b     <= 1'b0;
      pre_result <= '0;
      dvd        <= '0;
      rem        <= '0;
      bmag       <= '0;
      cnt        <= '0;
    end else if (!kill) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_op;
            rem_op_q <= rem_op;
          end
        end
        PREP: begin
          b_zero <= bz_c;
          a_lt_b <= lt_c;
          rem    <= '0;
          dvd    <= dvd_init;
          bmag   <= bmag_c;
          cnt    <= cnt_init;
          if (bz_c || lt_c) pre_result <= '0;
        end
        ITER: begin
          rem <= ge ? trial[XLEN-1:0] : sh[XLEN-1:0];
          dvd <= {dvd[XLEN-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        POST: pre_result <= rem_op_q ? r_c : q_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_iter_fsm.sv
// Bench for intdiv_iter_fsm: directed cases plus random ops vs a model.
// Honours INTDIV_EARLYTERM_EN for expected latency.
module tb_intdiv_iter_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic        signed_op = 1'b0;
  logic        rem_op = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy, done, rem_op_q, b_zero, a_lt_b;
  logic [63:0] a_q, b_q, pre_result;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] last_res = '0;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;

  intdiv_iter_fsm #(.XLEN(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .kill(kill), .a(a), .b(b), .signed_op(signed_op),
    .rem_op(rem_op), .busy(busy), .done(done),
    .a_q(a_q), .b_q(b_q), .rem_op_q(rem_op_q),
    .b_zero(b_zero), .a_lt_b(a_lt_b),
    .pre_result(pre_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_res(
    input logic [63:0] x, input logic [63:0] y,
    input bit s, input bit r,
    output bit bz, output bit lt, output int lat);
    logic [63:0] xm, ym, q, rm;
    longint sx, sy;
    int bl;
    xm = (s && x[63]) ? -x : x;
    ym = (s && y[63]) ? -y : y;
    bz = (y == 0);
    lt = !bz && (xm < ym);
    if (bz || lt) begin
      lat = 2;
      return '0;
    end
    if (!s) begin
      q  = x / y;
      rm = x % y;
    end else if (y == M1) begin
      q  = -x;
      rm = '0;
    end else begin
      sx = x;
      sy = y;
      q  = sx / sy;
      rm = sx % sy;
    end
    bl = 0;
    for (int i = 0; i < 64; i++) if (xm[i]) bl = i + 1;
`ifdef INTDIV_EARLYTERM_EN
    lat = bl + 3;
`else
    lat = 67;
`endif
    return r ? rm : q;
  endfunction

  task automatic run_op(input logic [63:0] ai,
                        input logic [63:0] bi,
                        input bit s, input bit r,
                        input bit busy_start,
                        input bit done_start);
    logic [63:0] exp;
    bit bz, lt;
    int lat, seen;
    exp = ref_res(ai, bi, s, r, bz, lt, lat);
    a = ai; b = bi; signed_op = s; rem_op = r;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("busy_prep", busy, 1);
    seen = 0;
    for (int k = 1; k <= 80 && seen == 0; k++) begin
      if (done) seen = k;
      else begin
        if (k == 3 && busy_start) begin
          a = ~ai; b = bi + 1; rem_op = ~r;
          start = 1'b1;
        end else start = 1'b0;
        step;
      end
    end
    start = 1'b0;
    chk("latency", seen, lat);
    if (seen != 0) begin
      chk("busy_done", busy, 0);
      chk("pre_result", pre_result, exp);
      chk("b_zero", b_zero, bz);
      chk("a_lt_b", a_lt_b, lt);
      chk("a_q", a_q, ai);
      chk("b_q", b_q, bi);
      chk("rem_op_q", rem_op_q, r);
      last_res = exp;
      if (done_start) begin
        a = ~ai;
        start = 1'b1;
        step;
        start = 1'b0;
        chk("done_start_ign", busy, 0);
        chk("a_q_hold", a_q, ai);
      end else step;
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    int d;
    logic [63:0] ra, rb;
    step;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_q", a_q, 0);
    chk("rst_res", pre_result, 0);
    chk("rst_flags", {b_zero, a_lt_b, rem_op_q}, 0);
    reset_n = 1'b1;
    step;

    run_op(100, 7, 0, 0, 0, 0);
    run_op(100, 7, 0, 1, 1, 1);
    run_op(-64'sd100, 7, 1, 0, 0, 0);
    run_op(-64'sd100, 7, 1, 1, 0, 0);
    run_op(100, -64'sd7, 1, 1, 0, 0);
    run_op(5, 0, 0, 0, 0, 0);
    run_op(5, 0, 1, 1, 0, 1);
    run_op(3, -64'sd10, 1, 0, 0, 0);
    run_op(MIN, M1, 1, 0, 0, 0);
    run_op(MIN, M1, 1, 1, 0, 0);
    run_op(M1, 1, 0, 0, 0, 0);
    run_op(M1, M1, 0, 1, 0, 0);

    // kill during iteration, with a start pulse while busy
    a = 100; b = 7; signed_op = 0; rem_op = 0;
    start = 1'b1;
    step;
    for (int k = 1; k < 20; k++) begin
      if (k == 5) begin
        a = 55; b = 3; start = 1'b1;
      end else start = 1'b0;
      step;
    end
    start = 1'b0;
    kill = 1'b1;
    step;
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    d = 0;
    for (int k = 0; k < 70; k++) begin
      if (done) d++;
      step;
    end
    chk("kill_nodone", d, 0);
    chk("kill_res", pre_result, last_res);
    chk("kill_a_q", a_q, 100);

    a = 9; b = 3; start = 1'b1; kill = 1'b1;
    step;
    start = 1'b0; kill = 1'b0;
    chk("kill_start_busy", busy, 0);
    step;
    chk("kill_start_a_q", a_q, 100);

    // asynchronous reset mid-operation
    a = 1000; b = 3; signed_op = 0; rem_op = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (5) step;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_a_q", a_q, 0);
    chk("mid_rst_flags", {b_zero, a_lt_b}, 0);
    step;
    reset_n = 1'b1;
    last_res = '0;
    step;

    for (int n = 0; n < 150; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ;
        1: begin
          rb = 64'($urandom_range(1, 1000));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        2: rb = '0;
        3: begin ra = MIN; rb = M1; end
        4: ra = 64'($urandom_range(0, 5000));
        default: rb = rb >> $urandom_range(0, 63);
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
